// File: rtl/pwm_fade_ctrl.sv
// Command front-end for the pwm block: accepts SET_TOP / SET_CMP / RESTART / FADE commands
// and drives the pwm d/sel programming bus. Fades move cmp one step per pwm period.
module pwm_fade_ctrl #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    input  logic [W-1:0] cmd_step,
    input  logic [W-1:0] pwm_cnt,
    output logic [W-1:0] d,
    output logic [1:0]   sel,
    output logic [W-1:0] cur_cmp,
    output logic [W-1:0] cur_top,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FADE_WAIT,
        FADE_WRITE
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic [W-1:0] target;
    logic [W-1:0] target_nx;
    logic [W-1:0] step;
    logic [W-1:0] step_nx;
    logic [W-1:0] prev_cnt;
    logic [W-1:0] d_nx;
    logic [W-1:0] cur_cmp_nx;
    logic [W-1:0] cur_top_nx;
    logic [W-1:0] fade_next;
    logic [1:0]   sel_nx;
    logic         busy_nx;
    logic         wrap;
    logic         up;
    logic [W:0]   gap;

    assign wrap = (pwm_cnt == '0) && (prev_cnt != '0);

    // Distance to target is taken one bit wider, so the step never over/undershoots.
    always_comb begin
        up  = (target >= cur_cmp);
        gap = up ? ({1'b0, target} - {1'b0, cur_cmp})
                 : ({1'b0, cur_cmp} - {1'b0, target});
        if (gap <= {1'b0, step}) begin
            fade_next = target;
        end else if (up) begin
            fade_next = cur_cmp + step;
        end else begin
            fade_next = cur_cmp - step;
        end
    end

    // Writes are registered at the accept edge, so WRITE is the cycle the pulse is visible.
    always_comb begin
        state_nx   = state;
        sel_nx     = '0;
        d_nx       = d;
        cur_cmp_nx = cur_cmp;
        cur_top_nx = cur_top;
        target_nx  = target;
        step_nx    = step;
        busy_nx    = busy;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    unique case (cmd_op)
                        2'd0: begin
                            sel_nx     = 2'd2;
                            d_nx       = cmd_data;
                            cur_top_nx = cmd_data;
                            state_nx   = WRITE;
                        end
                        2'd1: begin
                            sel_nx     = 2'd1;
                            d_nx       = cmd_data;
                            cur_cmp_nx = cmd_data;
                            state_nx   = WRITE;
                        end
                        2'd3: begin
                            sel_nx   = 2'd3;
                            d_nx     = cmd_data;
                            state_nx = WRITE;
                        end
                        default: begin
                            target_nx = cmd_data;
                            step_nx   = (cmd_step == '0) ? W'(1) : cmd_step;
                            if (cmd_data != cur_cmp) begin
                                busy_nx  = 1'b1;
                                state_nx = FADE_WAIT;
                            end
                        end
                    endcase
                end
            end
            WRITE: begin
                state_nx = IDLE;
            end
            FADE_WAIT: begin
                if (wrap) begin
                    state_nx = FADE_WRITE;
                end
            end
            FADE_WRITE: begin
                sel_nx     = 2'd1;
                d_nx       = fade_next;
                cur_cmp_nx = fade_next;
                if (fade_next == target) begin
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end else begin
                    state_nx = FADE_WAIT;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            sel       <= '0;
            d         <= '0;
            cur_cmp   <= '0;
            cur_top   <= '0;
            target    <= '0;
            step      <= '0;
            busy      <= 1'b0;
            prev_cnt  <= '0;
        end else begin
            state     <= state_nx;
            cmd_ready <= (state_nx == IDLE);
            sel       <= sel_nx;
            d         <= d_nx;
            cur_cmp   <= cur_cmp_nx;
            cur_top   <= cur_top_nx;
            target    <= target_nx;
            step      <= step_nx;
            busy      <= busy_nx;
            prev_cnt  <= pwm_cnt;
        end
    end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl with a small behavioural pwm counter closing the wrap loop.
module tb_pwm_fade_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = '0;
    logic [W-1:0] cmd_data = '0;
    logic [W-1:0] cmd_step = '0;
    logic [W-1:0] pwm_cnt;
    logic [W-1:0] d;
    logic [1:0]   sel;
    logic [W-1:0] cur_cmp;
    logic [W-1:0] cur_top;
    logic         busy;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int npulse = 0;
    logic [W-1:0] wlog[$];
    int           wcyc[$];
    logic [W-1:0] m_top = '0;
    logic [W-1:0] m_cnt = '0;

    pwm_fade_ctrl #(.W(W)) dut (
        .clk(clk), .nrst(nrst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_step(cmd_step), .pwm_cnt(pwm_cnt),
        .d(d), .sel(sel), .cur_cmp(cur_cmp), .cur_top(cur_top), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Downstream pwm: register writes via sel, free-running 0..top counter otherwise.
    assign pwm_cnt = m_cnt;
    always @(posedge clk) begin
        case (sel)
            2'd2:    m_top <= d;
            2'd3:    m_cnt <= d;
            2'd1:    m_cnt <= (m_cnt >= m_top) ? '0 : m_cnt + 1'b1;
            default: m_cnt <= (m_cnt >= m_top) ? '0 : m_cnt + 1'b1;
        endcase
    end

    always @(negedge clk) begin
        if (sel != 2'd0) begin
            npulse++;
            if (sel == 2'd1) begin
                wlog.push_back(d);
                wcyc.push_back(cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] data, input logic [W-1:0] stp);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_step  = stp;
        check("ready_before_send", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        check("fade_timeout", 32'(busy), 0);
    endtask

    initial begin
        int p0;
        int bad;
        int rdy_bad;

        // Reset state
        #12;
        check("rst_sel", 32'(sel), 0);
        check("rst_d", 32'(d), 0);
        check("rst_cur_cmp", 32'(cur_cmp), 0);
        check("rst_cur_top", 32'(cur_top), 0);
        check("rst_busy", 32'(busy), 0);
        @(negedge clk);
        nrst = 1'b1;
        tick();
        check("ready_after_rst", 32'(cmd_ready), 1);

        // SET_TOP 99: pulse in cycle N+1 only, ready back at N+2
        send(2'd0, 16'd99, '0);
        check("settop_sel", 32'(sel), 2);
        check("settop_d", 32'(d), 99);
        check("settop_cur_top", 32'(cur_top), 99);
        check("settop_ready_low", 32'(cmd_ready), 0);
        tick();
        check("settop_sel_clear", 32'(sel), 0);
        check("settop_d_hold", 32'(d), 99);
        check("settop_ready_high", 32'(cmd_ready), 1);

        // RESTART leaves both shadows alone
        send(2'd3, 16'd4, '0);
        check("restart_sel", 32'(sel), 3);
        check("restart_d", 32'(d), 4);
        check("restart_cur_top", 32'(cur_top), 99);
        check("restart_cur_cmp", 32'(cur_cmp), 0);
        tick();

        // top=9, cmp=0, fade to 5 step 2 -> 2,4,5 one period apart
        send(2'd0, 16'd9, '0);
        tick();
        send(2'd1, 16'd0, '0);
        tick();
        wlog.delete();
        wcyc.delete();
        send(2'd2, 16'd5, 16'd2);
        check("fade_busy", 32'(busy), 1);
        check("fade_ready_low", 32'(cmd_ready), 0);
        wait_idle(200);
        @(negedge clk);
        #1;
        check("fade_nwrites", 32'(wlog.size()), 3);
        if (wlog.size() == 3) begin
            check("fade_w0", 32'(wlog[0]), 2);
            check("fade_w1", 32'(wlog[1]), 4);
            check("fade_w2", 32'(wlog[2]), 5);
            check("fade_gap01", 32'(wcyc[1] - wcyc[0]), 10);
            check("fade_gap12", 32'(wcyc[2] - wcyc[1]), 10);
        end
        check("fade_cur_cmp", 32'(cur_cmp), 5);
        tick();

        // cmp=200, fade to 3 with step 0 (acts as 1): 199 down to 3
        send(2'd1, 16'd200, '0);
        tick();
        wlog.delete();
        send(2'd2, 16'd3, 16'd0);
        wait_idle(2500);
        @(negedge clk);
        #1;
        check("down_nwrites", 32'(wlog.size()), 197);
        bad = 0;
        for (int i = 0; i < wlog.size(); i++) begin
            if (wlog[i] !== 16'(199 - i)) bad++;
        end
        check("down_sequence_errors", 32'(bad), 0);
        check("down_cur_cmp", 32'(cur_cmp), 3);
        tick();

        // cmd_valid held through a fade: accepted on the edge after busy drops
        wlog.delete();
        p0 = npulse;
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_data  = 16'd6;
        cmd_step  = 16'd1;
        tick();
        cmd_op   = 2'd1;
        cmd_data = 16'd77;
        rdy_bad  = 0;
        for (int n = 0; n < 200 && busy; n++) begin
            if (cmd_ready) rdy_bad++;
            tick();
        end
        check("hold_timeout", 32'(busy), 0);
        check("hold_ready_while_busy", 32'(rdy_bad), 0);
        check("hold_last_fade_sel", 32'(sel), 1);
        check("hold_last_fade_d", 32'(d), 6);
        tick();
        cmd_valid = 1'b0;
        check("hold_accept_sel", 32'(sel), 1);
        check("hold_accept_d", 32'(d), 77);
        check("hold_cur_cmp", 32'(cur_cmp), 77);
        tick();
        tick();
        check("hold_pulses", 32'(npulse - p0), 4);
        if (wlog.size() == 4) begin
            check("hold_w0", 32'(wlog[0]), 4);
            check("hold_w2", 32'(wlog[2]), 6);
        end else begin
            check("hold_nwrites", 32'(wlog.size()), 4);
        end

        // FADE to the current cmp: no busy, no write
        p0 = npulse;
        send(2'd2, 16'd77, 16'd5);
        check("same_busy", 32'(busy), 0);
        check("same_sel", 32'(sel), 0);
        check("same_ready", 32'(cmd_ready), 1);
        repeat (30) tick();
        check("same_no_pulses", 32'(npulse - p0), 0);
        check("same_busy_late", 32'(busy), 0);

        // Asynchronous reset in the middle of a fade
        send(2'd2, 16'd10, 16'd1);
        repeat (25) tick();
        check("midfade_busy", 32'(busy), 1);
        #2;
        nrst = 1'b0;
        #1;
        check("async_rst_sel", 32'(sel), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_cur_cmp", 32'(cur_cmp), 0);
        check("async_rst_cur_top", 32'(cur_top), 0);
        @(negedge clk);
        nrst = 1'b1;
        tick();
        check("post_rst_ready", 32'(cmd_ready), 1);
        check("post_rst_busy", 32'(busy), 0);
        repeat (20) tick();
        check("post_rst_idle_sel", 32'(sel), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
